// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: load / step / readout sequencer for the Game-of-Life PE array.
// Optional build macro PE_CTRL_STALL_DETECT_EN ends a run early once the array goes inactive.
module pe_array_ctrl #(
  parameter int N_PX       = 8,
  parameter int N_PY       = 8,
  parameter int X_BITS     = 3,
  parameter int Y_BITS     = 3,
  parameter int CMD_BITS   = 2,
  parameter int STATE_BITS = 1,
  parameter int CMD_NOP    = 0,
  parameter int CMD_LOAD   = 1,
  parameter int CMD_STEP   = 2,
  parameter int SETTLE     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic                  start_run,
  input  logic                  start_read,
  input  logic                  abort,
  input  logic [15:0]           gen_count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [STATE_BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STATE_BITS-1:0] out_data,
  output logic [STATE_BITS-1:0] out_prev,
  output logic                  out_last,
  output logic [CMD_BITS-1:0]   cmd,
  output logic [STATE_BITS-1:0] state_in,
  output logic [X_BITS-1:0]     adr_x_i,
  output logic [Y_BITS-1:0]     adr_y_i,
  output logic [X_BITS-1:0]     adr_x_o,
  output logic [Y_BITS-1:0]     adr_y_o,
  input  logic [STATE_BITS-1:0] arr_state,
  input  logic [STATE_BITS-1:0] arr_prev,
  input  logic                  arr_active,
  output logic                  busy,
  output logic                  load_done,
  output logic                  run_done,
  output logic [15:0]           gens_run,
  output logic                  stalled
);
  localparam logic [CMD_BITS-1:0] C_NOP  = CMD_BITS'(CMD_NOP);
  localparam logic [CMD_BITS-1:0] C_LOAD = CMD_BITS'(CMD_LOAD);
  localparam logic [CMD_BITS-1:0] C_STEP = CMD_BITS'(CMD_STEP);
  localparam logic [X_BITS-1:0]   X_MAX  = X_BITS'(N_PX - 1);
  localparam logic [Y_BITS-1:0]   Y_MAX  = Y_BITS'(N_PY - 1);
  localparam logic [3:0]          WAIT_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT, READ} state_t;

  state_t                  state_reg, state_next;
  logic [X_BITS-1:0]       x_reg, x_next;
  logic [Y_BITS-1:0]       y_reg, y_next;
  logic [3:0]              wait_cnt_reg, wait_cnt_next;
  logic [15:0]             target_reg, target_next;
  logic [15:0]             gens_run_reg, gens_run_next;
  logic                    stalled_reg, stalled_next;
  logic [CMD_BITS-1:0]     cmd_reg, cmd_next;
  logic [STATE_BITS-1:0]   state_in_reg, state_in_next;
  logic [X_BITS-1:0]       adr_x_i_reg, adr_x_i_next;
  logic [Y_BITS-1:0]       adr_y_i_reg, adr_y_i_next;
  logic                    out_valid_reg, out_valid_next;
  logic [STATE_BITS-1:0]   out_data_reg, out_data_next;
  logic [STATE_BITS-1:0]   out_prev_reg, out_prev_next;
  logic                    out_last_reg, out_last_next;
  logic                    busy_reg, busy_next;
  logic                    load_done_reg, load_done_next;
  logic                    run_done_reg, run_done_next;

  logic        last_cell;
  logic [15:0] gens_inc;
  logic        stall_hit;

  assign last_cell = (x_reg == X_MAX) && (y_reg == Y_MAX);
  assign gens_inc  = gens_run_reg + 16'd1;

`ifdef PE_CTRL_STALL_DETECT_EN
  assign stall_hit = !arr_active;
`else
  logic unused_active;
  assign unused_active = arr_active;
  assign stall_hit     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      wait_cnt_reg  <= '0;
      target_reg    <= '0;
      gens_run_reg  <= '0;
      stalled_reg   <= 1'b0;
      cmd_reg       <= C_NOP;
      state_in_reg  <= '0;
      adr_x_i_reg   <= '0;
      adr_y_i_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_prev_reg  <= '0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      load_done_reg <= 1'b0;
      run_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      wait_cnt_reg  <= wait_cnt_next;
      target_reg    <= target_next;
      gens_run_reg  <= gens_run_next;
      stalled_reg   <= stalled_next;
      cmd_reg       <= cmd_next;
      state_in_reg  <= state_in_next;
      adr_x_i_reg   <= adr_x_i_next;
      adr_y_i_reg   <= adr_y_i_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_prev_reg  <= out_prev_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
      load_done_reg <= load_done_next;
      run_done_reg  <= run_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    wait_cnt_next  = wait_cnt_reg;
    target_next    = target_reg;
    gens_run_next  = gens_run_reg;
    stalled_next   = stalled_reg;
    cmd_next       = C_NOP;
    state_in_next  = state_in_reg;
    adr_x_i_next   = adr_x_i_reg;
    adr_y_i_next   = adr_y_i_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_prev_next  = out_prev_reg;
    out_last_next  = out_last_reg;
    load_done_next = 1'b0;
    run_done_next  = 1'b0;

    if (abort) begin
      state_next     = IDLE;
      out_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_load) begin
            state_next = LOAD;
            x_next     = '0;
            y_next     = '0;
          end else if (start_run) begin
            target_next   = gen_count;
            gens_run_next = '0;
            stalled_next  = 1'b0;
            if (gen_count == 16'd0) begin
              run_done_next = 1'b1;
            end else begin
              state_next = STEP;
              cmd_next   = C_STEP;
            end
          end else if (start_read) begin
            state_next     = READ;
            x_next         = '0;
            y_next         = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            cmd_next      = C_LOAD;
            state_in_next = in_data;
            adr_x_i_next  = x_reg;
            adr_y_i_next  = y_reg;
            if (last_cell) begin
              state_next     = IDLE;
              load_done_next = 1'b1;
            end else if (x_reg == X_MAX) begin
              x_next = '0;
              y_next = y_reg + Y_BITS'(1);
            end else begin
              x_next = x_reg + X_BITS'(1);
            end
          end
        end
        STEP: begin
          state_next    = WAIT;
          wait_cnt_next = '0;
        end
        WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            gens_run_next = gens_inc;
            if (gens_inc == target_reg || stall_hit) begin
              state_next    = IDLE;
              run_done_next = 1'b1;
              stalled_next  = stall_hit;
            end else begin
              state_next = STEP;
              cmd_next   = C_STEP;
            end
          end else begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
          end
        end
        READ: begin
          if (out_valid_reg && out_ready && out_last_reg) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
          end else if (!out_valid_reg || (out_ready && !out_last_reg)) begin
            // The array is combinational from adr_*_o, so the cell under the counter is captured now.
            out_data_next  = arr_state;
            out_prev_next  = arr_prev;
            out_valid_next = 1'b1;
            out_last_next  = last_cell;
            if (!last_cell) begin
              if (x_reg == X_MAX) begin
                x_next = '0;
                y_next = y_reg + Y_BITS'(1);
              end else begin
                x_next = x_reg + X_BITS'(1);
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  assign in_ready  = (state_reg == LOAD);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_prev  = out_prev_reg;
  assign out_last  = out_last_reg;
  assign cmd       = cmd_reg;
  assign state_in  = state_in_reg;
  assign adr_x_i   = adr_x_i_reg;
  assign adr_y_i   = adr_y_i_reg;
  assign adr_x_o   = x_reg;
  assign adr_y_o   = y_reg;
  assign busy      = busy_reg;
  assign load_done = load_done_reg;
  assign run_done  = run_done_reg;
  assign gens_run  = gens_run_reg;
  assign stalled   = stalled_reg;
endmodule
